// File: rtl/iob_cache_back_end_mem.sv
// iob_cache_back_end_mem: memory-side initiator of the cache.
// It drains write-through buffer entries as single-word writes and fetches whole
// lines word by word for misses, handing each word to the fill path as it arrives.
// Optional build macro CACHE_BE_CNT_EN adds write/fill event counters
// (cnt_clr, wr_cnt, fill_cnt).
module iob_cache_back_end_mem #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  localparam int NBYTES    = DATA_W / 8,
  localparam int OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wtb_empty,
  input  logic [ADDR_W+DATA_W+NBYTES-1:0] wtb_rdata,
  output logic                           wtb_rd,
  input  logic                           fill_req,
  input  logic [ADDR_W-1:0]              fill_addr,
  output logic                           fill_valid,
  output logic [OFF_W-1:0]               fill_word,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           fill_done,
  output logic                           busy,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  output logic [NBYTES-1:0]              mem_wstrb,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ack
`ifdef CACHE_BE_CNT_EN
  ,
  input  logic                           cnt_clr,
  output logic [31:0]                    wr_cnt,
  output logic [31:0]                    fill_cnt
`endif
);

  localparam int BO = $clog2(NBYTES);
  localparam logic [OFF_W-1:0]  LAST      = OFF_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << (OFF_W + BO)) - ADDR_W'(1));

  typedef enum logic [1:0] {IDLE, POP, WRITE, READ} state_t;

  state_t              state, state_nxt;
  logic [OFF_W-1:0]    cnt;
  logic [ADDR_W-1:0]   line_base;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NBYTES-1:0]   wr_strb;
  logic [ADDR_W-1:0]   rd_addr;

  // Word address within the line being fetched.
  assign rd_addr = line_base | (ADDR_W'(cnt) << BO);

  assign busy = (state != IDLE) || !wtb_empty;

  // State, word counter, captured buffer entry and latched line base.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      line_base <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strb   <= '0;
    end else begin
      state <= state_nxt;
      if (state == POP)
        {wr_addr, wr_data, wr_strb} <= wtb_rdata;
      if (state == IDLE && wtb_empty && fill_req) begin
        line_base <= fill_addr & LINE_MASK;
        cnt       <= '0;
      end
      // Counter is a power of two wide, so the last word wraps it back to 0.
      if (fill_valid)
        cnt <= cnt + OFF_W'(1);
    end
  end

  // Next state and all memory/fill outputs; writes win over fills in IDLE.
  always_comb begin
    state_nxt  = state;
    wtb_rd     = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    fill_valid = 1'b0;
    fill_word  = '0;
    fill_data  = '0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!wtb_empty) begin
          // Pop strobe is masked while reset is held so nothing is lost.
          wtb_rd    = reset;
          state_nxt = POP;
        end else if (fill_req) begin
          state_nxt = READ;
        end
      end
      POP: state_nxt = WRITE;
      WRITE: begin
        mem_req   = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_wstrb = wr_strb;
        if (mem_ack) state_nxt = IDLE;
      end
      READ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr;
        if (mem_ack) begin
          fill_valid = 1'b1;
          fill_word  = cnt;
          fill_data  = mem_rdata;
          fill_done  = (cnt == LAST);
          if (cnt == LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CACHE_BE_CNT_EN
  // Saturating event counters; clear has priority over a same-cycle event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cnt   <= '0;
      fill_cnt <= '0;
    end else if (cnt_clr) begin
      wr_cnt   <= '0;
      fill_cnt <= '0;
    end else begin
      if (state == WRITE && mem_ack && wr_cnt != '1)
        wr_cnt <= wr_cnt + 32'd1;
      if (fill_done && fill_cnt != '1)
        fill_cnt <= fill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iob_cache_back_end_mem.sv
// Self-checking bench for iob_cache_back_end_mem (default parameters).
// A transaction-level model holds the ordered list of memory operations the
// stimulus implies; a compare process checks every cycle against it.
module tb_iob_cache_back_end_mem;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wtb_empty;
  logic [67:0] wtb_rdata;
  logic        wtb_rd;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic        fill_valid;
  logic [1:0]  fill_word;
  logic [31:0] fill_data;
  logic        fill_done;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef CACHE_BE_CNT_EN
  logic        cnt_clr;
  logic [31:0] wr_cnt;
  logic [31:0] fill_cnt;
`endif

  iob_cache_back_end_mem dut (
    .clk(clk), .reset(reset),
    .wtb_empty(wtb_empty), .wtb_rdata(wtb_rdata), .wtb_rd(wtb_rd),
    .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_valid(fill_valid), .fill_word(fill_word), .fill_data(fill_data),
    .fill_done(fill_done), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_BE_CNT_EN
    , .cnt_clr(cnt_clr), .wr_cnt(wr_cnt), .fill_cnt(fill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  txn_t        exp_q[$];
  logic [67:0] wtb_q[$];

  // responder configuration
  bit ack_block = 1'b0;
  bit stall_rand = 1'b0;
  bit spur_en = 1'b0;
  int stall_fixed = 0;
  int stall_tgt = 0;
  int wait_cnt = 0;

  // checker statistics
  int cyc = 0, rd_cyc = 0, last_lat = -1;
  int rd_pulses = 0, req_cycles = 0, writes_done = 0, fills_done = 0;
  bit prev_pend = 1'b0, prev_req = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;
  bit pop_pend = 1'b0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_stall(input int n);
    stall_rand = 1'b0; stall_fixed = n; stall_tgt = n; wait_cnt = 0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.addr = a; t.wdata = d; t.wstrb = s;
    wtb_q.push_back({a, d, s});
    exp_q.push_back(t);
    wtb_empty = 1'b0;
  endtask

  // Queue the four word reads of the line holding addr and raise the request.
  task automatic start_fill(input logic [31:0] addr);
    txn_t t;
    for (int w = 0; w < 4; w++) begin
      t.addr = {addr[31:4], 4'h0} + 32'(w * 4); t.wdata = '0; t.wstrb = '0;
      exp_q.push_back(t);
    end
    fill_addr = addr;
    fill_req  = 1'b1;
  endtask

  task automatic wait_req(input int max);
    int k;
    for (k = 0; k < max; k++) begin
      @(negedge clk); #1;
      if (mem_req) break;
    end
    if (k == max) begin
      n_checks++; n_fail++;
      $display("FAIL wait_req: timeout, mem_req never rose within %0d cycles", max);
    end
  endtask

  task automatic wait_done(input int max);
    int k;
    for (k = 0; k < max; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && wtb_q.size() == 0) break;
    end
    if (k == max) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: timeout, %0d txns outstanding", exp_q.size());
      exp_q.delete();
    end
    tick();
    fill_req = 1'b0;
    @(negedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_req", mem_req, 0);
  endtask

  // Write-through buffer: pop on wtb_rd, data visible the following cycle.
  always @(negedge clk) pop_pend = wtb_rd;
  always @(posedge clk) begin
    #1;
    if (pop_pend && wtb_q.size() > 0) wtb_rdata = wtb_q.pop_front();
    pop_pend = 1'b0;
    wtb_empty = (wtb_q.size() == 0);
  end

  // Memory responder: acks after a configurable stall, optional stray acks.
  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (mem_req && !ack_block) begin
      if (wait_cnt >= stall_tgt) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_fn(mem_addr);
        wait_cnt  = 0;
        stall_tgt = stall_rand ? int'($urandom_range(5, 0)) : stall_fixed;
      end else begin
        wait_cnt++;
      end
    end else if (!mem_req) begin
      wait_cnt = 0;
      if (spur_en) mem_ack = 1'($urandom_range(1, 0));
    end
  end

  // Compare process: every cycle out of reset, check outputs against the model.
  always @(negedge clk) begin
    txn_t e;
    cyc++;
    if (reset !== 1'b1) begin
      prev_pend = 1'b0;
      prev_req  = 1'b0;
    end else begin
      if (wtb_rd) begin
        rd_pulses++;
        rd_cyc = cyc;
      end
      if (prev_pend) begin
        chk("req_held", mem_req, 1);
        chk("addr_stable", mem_addr, prev_addr);
        chk("wdata_stable", mem_wdata, prev_wdata);
        chk("wstrb_stable", mem_wstrb, prev_wstrb);
      end
      if (mem_req) begin
        req_cycles++;
        if (!prev_req) last_lat = cyc - rd_cyc;
      end
      if (mem_req || !wtb_empty) chk("busy_active", busy, 1);
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_txn: addr 0x%0h wstrb 0x%0h with none expected", mem_addr, mem_wstrb);
        end else begin
          e = exp_q.pop_front();
          chk("txn_addr", mem_addr, e.addr);
          chk("txn_wdata", mem_wdata, e.wdata);
          chk("txn_wstrb", mem_wstrb, e.wstrb);
          if (e.wstrb == 4'h0) begin
            chk("fill_valid", fill_valid, 1);
            chk("fill_word", fill_word, e.addr[3:2]);
            chk("fill_data", fill_data, rd_fn(e.addr));
            chk("fill_done", fill_done, e.addr[3:2] == 2'd3);
            if (e.addr[3:2] == 2'd3) fills_done++;
          end else begin
            chk("wr_no_fill", {fill_valid, fill_done}, 0);
            writes_done++;
          end
        end
      end else begin
        chk("no_fill", {fill_valid, fill_done}, 0);
      end
      prev_pend  = mem_req && !mem_ack;
      prev_req   = mem_req;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_wstrb = mem_wstrb;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rp0, rq0, fd0, wd0, k;
    reset = 1'b0; fill_req = 1'b0; fill_addr = '0;
    wtb_empty = 1'b1; wtb_rdata = '0; mem_ack = 1'b0; mem_rdata = '0;
`ifdef CACHE_BE_CNT_EN
    cnt_clr = 1'b0;
`endif
    set_stall(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wtb_rd", wtb_rd, 0);
    chk("rst_fill", {fill_valid, fill_done}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_bus", {mem_addr, mem_wdata, mem_wstrb}, 0);
`ifdef CACHE_BE_CNT_EN
    chk("rst_cnts", {wr_cnt, fill_cnt}, 0);
`endif

    // Reset held 3 cycles in the middle of a stalled write.
    tick();
    ack_block = 1'b1;
    push_wr(32'h40, 32'h1111_2222, 4'h3);
    wait_req(20);
    tick();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mrst_mem_req", mem_req, 0);
    chk("mrst_wtb_rd", wtb_rd, 0);
    chk("mrst_fill_valid", fill_valid, 0);
    chk("mrst_busy_empty", busy, 0);
    tick();
    push_wr(32'h80, 32'hCAFE_F00D, 4'hF);
    @(negedge clk); #1;
    chk("mrst_busy_nonempty", busy, 1);
    chk("mrst_wtb_rd_held", wtb_rd, 0);
    chk("mrst_mem_req2", mem_req, 0);
    tick();
    reset = 1'b1;
    ack_block = 1'b0;
    wait_done(50);

    // Single write, ack in the third request cycle.
    tick();
    set_stall(2);
    rp0 = rd_pulses; rq0 = req_cycles;
    push_wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    wait_done(50);
    chk("wr_pops", rd_pulses - rp0, 1);
    chk("wr_req_cycles", req_cycles - rq0, 3);
    chk("wr_latency", last_lat, 2);

    // Line fill with same-cycle acks: 0x1230..0x123C back to back.
    tick();
    set_stall(0);
    rq0 = req_cycles; fd0 = fills_done;
    start_fill(32'h1234);
    wait_done(50);
    chk("fill_req_cycles", req_cycles - rq0, 4);
    chk("fill_done_cnt", fills_done - fd0, 1);

    // Fill request together with two buffered writes: writes go first.
    tick();
    fd0 = fills_done; wd0 = writes_done;
    push_wr(32'h200, 32'hA0A0_A0A0, 4'h1);
    push_wr(32'h204, 32'h0B0B_0B0B, 4'hC);
    start_fill(32'h3008);
    wait_done(80);
    chk("mix_writes", writes_done - wd0, 2);
    chk("mix_fills", fills_done - fd0, 1);

    // Random stalls, stray acks, request dropped mid-fill.
    tick();
    stall_rand = 1'b1; stall_tgt = 3; wait_cnt = 0; spur_en = 1'b1;
    fd0 = fills_done;
    start_fill(32'h4FFC);
    wait_req(20);
    tick();
    fill_req = 1'b0;
    wait_done(200);
    chk("drop_fill_done", fills_done - fd0, 1);

    // A write arriving during a fill waits for the line to complete.
    tick();
    fd0 = fills_done; wd0 = writes_done;
    start_fill(32'hABCD_EF07);
    wait_req(20);
    tick();
    push_wr(32'h300, 32'h1234_5678, 4'h6);
    wait_done(200);
    chk("late_wr_fills", fills_done - fd0, 1);
    chk("late_wr_writes", writes_done - wd0, 1);
    spur_en = 1'b0;

`ifdef CACHE_BE_CNT_EN
    // Event counters: 3 writes, 2 fills, then a clear colliding with a write ack.
    tick();
    set_stall(0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk); #1;
    chk("cnt_cleared", {wr_cnt, fill_cnt}, 0);
    tick();
    push_wr(32'h400, 32'h1, 4'hF);
    push_wr(32'h404, 32'h2, 4'hF);
    push_wr(32'h408, 32'h3, 4'hF);
    wait_done(80);
    tick();
    start_fill(32'h5000);
    wait_done(50);
    tick();
    start_fill(32'h6000);
    wait_done(50);
    chk("wr_cnt", wr_cnt, 3);
    chk("fill_cnt", fill_cnt, 2);
    tick();
    set_stall(1);
    push_wr(32'h500, 32'h5, 4'hF);
    for (k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (mem_req && mem_ack) break;
    end
    if (k == 30) begin
      n_checks++; n_fail++;
      $display("FAIL clr_ack_wait: timeout waiting for write ack");
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk); #1;
    chk("clr_wins", {wr_cnt, fill_cnt}, 0);
    wait_done(50);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
